rbcp_reg_slave: RTL and testbench

RBCP responder (register slave) for the SiTCP UDP register-access channel. It decodes the RBCP_ADDR/WD/WE/RE strobes issued by the SiTCP core and returns RBCP_ACK/RBCP_RD. It provides a firmware ID, a read/write control register, self-clearing pulse bits, a coherent 32-bit status snapshot and a saturating FIFO-full event counter. It sits in the CLK_200M domain beside the SiTCP wrapper; its ACK and RD outputs are ORed with those of other slaves.

---
 rtl/rbcp_reg_slave.sv | 135 +++++++++++++
 tb/tb_rbcp_reg_slave.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbcp_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : rbcp_reg_slave
// Purpose  : SiTCP RBCP register slave occupying a 16-byte window.
//            Provides a firmware ID, a control register, self-clearing
//            command pulses, a coherent 32-bit status snapshot and a
//            saturating count of FIFO-full rising edges.
// Ports    : CLK, RST (async, active-high)
//            RBCP_ADDR/WD/WE/RE : access strobes from the SiTCP core
//            RBCP_ACK/RD        : registered acknowledge and read data
//                                 (RD is 0 whenever ACK is 0 so slaves can be ORed)
//            STATUS_IN          : live status word
//            FIFO_FULL_IN       : TX FIFO almost-full level
//            CTRL_OUT           : control register
//            PULSE_OUT          : one-cycle command pulses
// Revision : 1.0 - initial release
// ============================================================================
module rbcp_reg_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] FW_ID     = 32'h4B37_0001,
  parameter logic [7:0]  CTRL_RST  = 8'h00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] RBCP_ADDR,
  input  logic [7:0]  RBCP_WD,
  input  logic        RBCP_WE,
  input  logic        RBCP_RE,
  output logic        RBCP_ACK,
  output logic [7:0]  RBCP_RD,
  input  logic [31:0] STATUS_IN,
  input  logic        FIFO_FULL_IN,
  output logic [7:0]  CTRL_OUT,
  output logic [7:0]  PULSE_OUT
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic        ack;
  logic [7:0]  rd_data;
  logic [7:0]  ctrl;
  logic [7:0]  pulse;
  logic [31:0] status_snap;
  logic [31:0] cnt_snap;
  logic [31:0] fullcnt;
  logic [31:0] fullcnt_next;
  logic        fifo_prev;

  logic        hit;
  logic [3:0]  offset;
  logic        wr_hit;
  logic        rd_hit;
  logic        fifo_rise;
  logic        cnt_clr;
  logic [7:0]  read_byte;

  // Big-endian byte pick: index 0 is bits [31:24].
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  assign hit       = (RBCP_ADDR[31:4] == BASE_ADDR[31:4]);
  assign offset    = RBCP_ADDR[3:0];
  // A simultaneous WE+RE is a write; the read side is suppressed.
  assign wr_hit    = RBCP_WE & hit;
  assign rd_hit    = RBCP_RE & ~RBCP_WE & hit;
  assign fifo_rise = FIFO_FULL_IN & ~fifo_prev;
  assign cnt_clr   = wr_hit & (offset[3:2] == 2'b11);

  // Clear takes priority over a coincident edge; counting stops at all-ones.
  always_comb begin
    fullcnt_next = fullcnt;
    if (cnt_clr) begin
      fullcnt_next = 32'h0000_0000;
    end else if (fifo_rise && (fullcnt != CNT_MAX)) begin
      fullcnt_next = fullcnt + 32'd1;
    end
  end

  // The first byte of STATUS/FULLCNT comes from the live value; the rest
  // come from the snapshot taken by that first read.
  always_comb begin
    read_byte = 8'h00;
    case (offset[3:2])
      2'b00: read_byte = be_byte(FW_ID, offset[1:0]);
      2'b01: read_byte = (offset[1:0] == 2'b00) ? ctrl : 8'h00;
      2'b10: read_byte = (offset[1:0] == 2'b00) ? STATUS_IN[31:24]
                                                : be_byte(status_snap, offset[1:0]);
      default: read_byte = (offset[1:0] == 2'b00) ? fullcnt[31:24]
                                                  : be_byte(cnt_snap, offset[1:0]);
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack         <= 1'b0;
      rd_data     <= 8'h00;
      ctrl        <= CTRL_RST;
      pulse       <= 8'h00;
      status_snap <= 32'h0000_0000;
      cnt_snap    <= 32'h0000_0000;
      fullcnt     <= 32'h0000_0000;
      fifo_prev   <= 1'b0;
    end else begin
      ack       <= wr_hit | rd_hit;
      rd_data   <= rd_hit ? read_byte : 8'h00;
      pulse     <= (wr_hit && offset == 4'h5) ? RBCP_WD : 8'h00;
      fifo_prev <= FIFO_FULL_IN;
      fullcnt   <= fullcnt_next;
      if (wr_hit && offset == 4'h4) begin
        ctrl <= RBCP_WD;
      end
      if (rd_hit && offset == 4'h8) begin
        status_snap <= STATUS_IN;
      end
      if (rd_hit && offset == 4'hC) begin
        cnt_snap <= fullcnt;
      end
    end
  end

  assign RBCP_ACK  = ack;
  assign RBCP_RD   = rd_data;
  assign CTRL_OUT  = ctrl;
  assign PULSE_OUT = pulse;

endmodule
`default_nettype wire

// File: tb/tb_rbcp_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_rbcp_reg_slave
// Purpose  : Scoreboard bench for rbcp_reg_slave. The driver updates a
//            register-map model and queues expected responses; a monitor
//            compares ACK/RD/CTRL_OUT/PULSE_OUT every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rbcp_reg_slave;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] FWID = 32'h4B37_0001;
  localparam logic [7:0]  CRST = 8'h5A;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] RBCP_ADDR = '0;
  logic [7:0]  RBCP_WD = '0;
  logic        RBCP_WE = 1'b0;
  logic        RBCP_RE = 1'b0;
  logic        RBCP_ACK;
  logic [7:0]  RBCP_RD;
  logic [31:0] STATUS_IN = '0;
  logic        FIFO_FULL_IN = 1'b0;
  logic [7:0]  CTRL_OUT;
  logic [7:0]  PULSE_OUT;

  rbcp_reg_slave #(
    .BASE_ADDR(BASE),
    .FW_ID    (FWID),
    .CTRL_RST (CRST)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RBCP_ADDR   (RBCP_ADDR),
    .RBCP_WD     (RBCP_WD),
    .RBCP_WE     (RBCP_WE),
    .RBCP_RE     (RBCP_RE),
    .RBCP_ACK    (RBCP_ACK),
    .RBCP_RD     (RBCP_RD),
    .STATUS_IN   (STATUS_IN),
    .FIFO_FULL_IN(FIFO_FULL_IN),
    .CTRL_OUT    (CTRL_OUT),
    .PULSE_OUT   (PULSE_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned due;
    logic [7:0]  rd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  // Reference model state (value each register holds after the next edge)
  logic [7:0]  m_ctrl  = CRST;
  logic [7:0]  m_pulse = 8'h00;
  logic [31:0] m_cnt   = 32'h0;
  logic [31:0] m_ssnap = 32'h0;
  logic [31:0] m_csnap = 32'h0;
  logic        m_prev  = 1'b0;

  logic        cur_fifo   = 1'b0;
  logic [31:0] cur_status = 32'h0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] word_byte(input logic [31:0] w, input int idx);
    return 8'(w >> (8 * (3 - idx)));
  endfunction

  // Monitor: every cycle, just after the edge
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      check8("ctrl_out", CTRL_OUT, m_ctrl);
      check8("pulse_out", PULSE_OUT, m_pulse);
      if (q.size() > 0 && q[0].due == cyc) begin
        check8("ack", {7'b0, RBCP_ACK}, 8'h01);
        check8("rd", RBCP_RD, q[0].rd);
        void'(q.pop_front());
      end else begin
        check8("ack_idle", {7'b0, RBCP_ACK}, 8'h00);
        check8("rd_idle", RBCP_RD, 8'h00);
      end
    end
  end

  task automatic model_reset();
    q.delete();
    m_ctrl  = CRST;
    m_pulse = 8'h00;
    m_cnt   = 32'h0;
    m_ssnap = 32'h0;
    m_csnap = 32'h0;
    m_prev  = 1'b0;
  endtask

  // One bus cycle: drive inputs at the falling edge and advance the model.
  task automatic drive(input logic we, input logic re, input logic [31:0] addr, input logic [7:0] wd);
    logic       hit, w, r, rise;
    logic [3:0] off;
    logic [7:0] rv;
    @(negedge CLK);
    RBCP_WE      = we;
    RBCP_RE      = re;
    RBCP_ADDR    = addr;
    RBCP_WD      = wd;
    FIFO_FULL_IN = cur_fifo;
    STATUS_IN    = cur_status;
    if (RST) return;
    hit  = (addr[31:4] == BASE[31:4]);
    off  = addr[3:0];
    w    = we && hit;
    r    = re && !we && hit;
    rise = cur_fifo && !m_prev;
    m_prev = cur_fifo;
    rv = 8'h00;
    if (off <= 4'h3)                    rv = word_byte(FWID, int'(off));
    else if (off == 4'h4)               rv = m_ctrl;
    else if (off == 4'h8)               rv = cur_status[31:24];
    else if (off >= 4'h9 && off <= 4'hB) rv = word_byte(m_ssnap, int'(off) - 8);
    else if (off == 4'hC)               rv = m_cnt[31:24];
    else if (off >= 4'hD)               rv = word_byte(m_csnap, int'(off) - 12);
    if (w || r) q.push_back('{due: cyc + 1, rd: (r ? rv : 8'h00)});
    if (r && off == 4'h8) m_ssnap = cur_status;
    if (r && off == 4'hC) m_csnap = m_cnt;
    if (w && off == 4'h4) m_ctrl = wd;
    m_pulse = (w && off == 4'h5) ? wd : 8'h00;
    if (w && off >= 4'hC)                     m_cnt = 32'h0;
    else if (rise && m_cnt != 32'hFFFF_FFFF)  m_cnt = m_cnt + 1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  task automatic rd(input logic [3:0] off);
    drive(1'b0, 1'b1, BASE + 32'(off), 8'h00);
  endtask

  task automatic wr(input logic [3:0] off, input logic [7:0] d);
    drive(1'b1, 1'b0, BASE + 32'(off), d);
  endtask

  task automatic fifo_edge();
    cur_fifo = 1'b1; idle();
    cur_fifo = 1'b0; idle();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    // Strobe coincident with reset must not be acknowledged
    RBCP_RE = 1'b1; RBCP_ADDR = BASE + 32'h4;
    @(negedge CLK);
    RBCP_RE = 1'b0; RBCP_WE = 1'b0; RBCP_ADDR = 32'h0;
    FIFO_FULL_IN = 1'b0; cur_fifo = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    idle();

    // 1: firmware ID, back-to-back reads
    for (int i = 0; i < 4; i++) rd(4'(i));
    idle();

    // 2: control register and command pulses
    wr(4'h4, 8'hA5); rd(4'h4); idle();
    wr(4'h5, 8'h81); idle(); rd(4'h5); rd(4'h6); rd(4'h7); idle();

    // 3: coherent status snapshot
    cur_status = 32'h1122_3344; rd(4'h8);
    cur_status = 32'hFFFF_FFFF; rd(4'h9); rd(4'hA); rd(4'hB); idle();

    // 4: FIFO-full edge counting, then clear racing an edge
    for (int i = 0; i < 5; i++) fifo_edge();
    cur_fifo = 1'b1;
    repeat (100) idle();
    for (int i = 12; i < 16; i++) rd(4'(i));
    cur_fifo = 1'b0; idle();
    cur_fifo = 1'b1; wr(4'hC, 8'h00);
    idle();
    for (int i = 12; i < 16; i++) rd(4'(i));
    cur_fifo = 1'b0; idle();

    // 5: miss, writes to read-only space, WE+RE together
    drive(1'b0, 1'b1, BASE + 32'h10, 8'h00);
    drive(1'b0, 1'b1, BASE - 32'h1, 8'h00);
    wr(4'h0, 8'hEE); wr(4'h9, 8'hEE); rd(4'h0);
    drive(1'b1, 1'b1, BASE + 32'h4, 8'h3C); idle(); rd(4'h4); idle();

    // 6a: reset while an ACK is pending on the bus
    wr(4'h4, 8'h77); rd(4'h4);
    @(posedge CLK); #2;
    RST = 1'b1;
    #1;
    check8("rst_ack_drop", {7'b0, RBCP_ACK}, 8'h00);
    check8("rst_rd_drop", RBCP_RD, 8'h00);
    check8("rst_ctrl", CTRL_OUT, CRST);
    model_reset();
    RBCP_RE = 1'b0; RBCP_WE = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    idle(); rd(4'h4); idle();
    do_reset();
    idle(); rd(4'hC); rd(4'hD); idle();

    // 6b: saturation from a preloaded count
    idle();
    force dut.fullcnt = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    idle();
    release dut.fullcnt;
    for (int i = 0; i < 3; i++) fifo_edge();
    for (int i = 12; i < 16; i++) rd(4'(i));
    idle();

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      int          sel;
      logic        we, re;
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       a = BASE + 32'($urandom_range(0, 15));
      else if (sel == 8) a = BASE + 32'h10;
      else               a = $urandom;
      we = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0) cur_fifo = ~cur_fifo;
      if ($urandom_range(0, 7) == 0) cur_status = $urandom;
      drive(we, re, a, 8'($urandom));
    end
    repeat (4) idle();

    check8("queue_drained", 8'(q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
